// File: rtl/mips_rtype_sequencer.sv
// Multi-cycle control FSM for an R-type MIPS datapath: FETCH, DECODE, EXECUTE, WRITEBACK.
// Define ILLEGAL_TRAP_EN to halt on an unsupported funct instead of retiring it as a NOP.
module mips_rtype_sequencer #(
  parameter int MAX_INSTR = 6,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [31:0]      INSTRUCTION,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUOp,
  output logic [3:0]       ALUCtl,
  output logic             BUSY,
  output logic             DONE,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] INSTR_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_DONE,
    S_HALT
  } state_e;

  localparam logic [CNT_W-1:0] MaxCount  = CNT_W'(MAX_INSTR);
  localparam logic [1:0]       AluOpRtype = 2'b10;

  state_e           state_q, state_d;
  logic [3:0]       alu_ctl_q, alu_ctl_d;
  logic             bad_funct_q, bad_funct_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;

  // Only the funct field drives control; the rest of the word belongs to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^INSTRUCTION[31:6];

  // Returns {illegal, alu_ctl}.
  function automatic logic [4:0] decode_funct(input logic [5:0] funct);
    case (funct)
      6'd32:   return {1'b0, 4'd2};
      6'd34:   return {1'b0, 4'd6};
      6'd36:   return {1'b0, 4'd0};
      6'd37:   return {1'b0, 4'd1};
      6'd39:   return {1'b0, 4'd12};
      6'd42:   return {1'b0, 4'd7};
      default: return {1'b1, 4'hF};
    endcase
  endfunction

  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d     = state_q;
    alu_ctl_d   = alu_ctl_q;
    bad_funct_d = bad_funct_q;
    illegal_d   = illegal_q;
    count_d     = count_q;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUOp       = 2'b00;
    BUSY        = 1'b0;
    DONE        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        DONE = (state_q == S_DONE);
        if (START) begin
          state_d   = S_FETCH;
          count_d   = '0;
          illegal_d = 1'b0;
        end
      end
      S_FETCH: begin
        BUSY    = 1'b1;
        PCWrite = 1'b1;
        IRWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        BUSY                     = 1'b1;
        {bad_funct_d, alu_ctl_d} = decode_funct(INSTRUCTION[5:0]);
        state_d                  = S_EXECUTE;
      end
      S_EXECUTE: begin
        BUSY    = 1'b1;
        ALUOp   = AluOpRtype;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        BUSY     = 1'b1;
        ALUOp    = AluOpRtype;
        RegWrite = !bad_funct_q;
`ifdef ILLEGAL_TRAP_EN
        if (bad_funct_q) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          count_d = count_inc;
          state_d = (count_inc == MaxCount) ? S_DONE : S_FETCH;
        end
`else
        // An unsupported funct retires as a NOP but leaves a sticky flag behind.
        if (bad_funct_q) illegal_d = 1'b1;
        count_d = count_inc;
        state_d = (count_inc == MaxCount) ? S_DONE : S_FETCH;
`endif
      end
      S_HALT: begin
        // Parked until RESET; every enable stays low.
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      alu_ctl_q   <= 4'hF;
      bad_funct_q <= 1'b0;
      illegal_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      alu_ctl_q   <= alu_ctl_d;
      bad_funct_q <= bad_funct_d;
      illegal_q   <= illegal_d;
      count_q     <= count_d;
    end
  end

  assign ALUCtl      = alu_ctl_q;
  assign ILLEGAL     = illegal_q;
  assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_mips_rtype_sequencer.sv
// Scoreboard bench for mips_rtype_sequencer: directed programs, reset, restart and illegal-funct runs.
// Honors ILLEGAL_TRAP_EN the same way the design does.
module tb_mips_rtype_sequencer;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [31:0]      instr;
  logic             pc_write, ir_write, reg_write;
  logic [1:0]       alu_op;
  logic [3:0]       alu_ctl;
  logic             busy, done, illegal;
  logic [CNT_W-1:0] count;

  // Second instance with MAX_INSTR=1 for the single-instruction boundary.
  logic             start_1;
  logic [31:0]      instr_1;
  logic             pc_write_1, ir_write_1, reg_write_1;
  logic [1:0]       alu_op_1;
  logic [3:0]       alu_ctl_1;
  logic             busy_1, done_1, illegal_1;
  logic [CNT_W-1:0] count_1;

  mips_rtype_sequencer #(.MAX_INSTR(6), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RESET(rst), .START(start), .INSTRUCTION(instr),
    .PCWrite(pc_write), .IRWrite(ir_write), .RegWrite(reg_write),
    .ALUOp(alu_op), .ALUCtl(alu_ctl), .BUSY(busy), .DONE(done),
    .ILLEGAL(illegal), .INSTR_COUNT(count)
  );

  mips_rtype_sequencer #(.MAX_INSTR(1), .CNT_W(CNT_W)) dut_1 (
    .CLK(clk), .RESET(rst), .START(start_1), .INSTRUCTION(instr_1),
    .PCWrite(pc_write_1), .IRWrite(ir_write_1), .RegWrite(reg_write_1),
    .ALUOp(alu_op_1), .ALUCtl(alu_ctl_1), .BUSY(busy_1), .DONE(done_1),
    .ILLEGAL(illegal_1), .INSTR_COUNT(count_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0] ctl;
    logic       reg_write;
  } wb_rec_t;

  wb_rec_t exp_q[$];

  task automatic push_exp(input logic [3:0] ctl, input logic rw);
    wb_rec_t rec;
    rec.ctl       = ctl;
    rec.reg_write = rw;
    exp_q.push_back(rec);
  endtask

  // Program memory: funct values with hand-decoded ALU control codes.
  logic [5:0] prog [6];
  int         fetch_idx;

  task automatic load_main_prog(input bit push);
    prog = '{6'd32, 6'd36, 6'd37, 6'd34, 6'd42, 6'd39};
    if (push) begin
      push_exp(4'd2, 1'b1);
      push_exp(4'd0, 1'b1);
      push_exp(4'd1, 1'b1);
      push_exp(4'd6, 1'b1);
      push_exp(4'd7, 1'b1);
      push_exp(4'd12, 1'b1);
    end
  endtask

  // Instruction source: presents the next word while FETCH loads it, held through DECODE.
  initial begin
    logic [31:0] r;
    instr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ir_write) begin
        r         = $urandom();
        instr     = {r[31:6], prog[fetch_idx % 6]};
        fetch_idx = fetch_idx + 1;
      end
    end
  end

  // Monitor: phase invariants every cycle, scoreboard compare at each WRITEBACK.
  initial begin
    logic       prev_hi;
    logic [3:0] exec_ctl;
    wb_rec_t    rec;
    prev_hi  = 1'b0;
    exec_ctl = 4'h0;
    forever begin
      @(negedge clk);
      check("ph_pc_ir_pair", pc_write, ir_write);
      if (pc_write) check("ph_fetch_only", {busy, alu_op, reg_write, done}, {1'b1, 2'b00, 1'b0, 1'b0});
      if (reg_write) check("ph_regwrite_in_wb", alu_op, 2'b10);
      if (alu_op != 2'b00) check("ph_aluop_busy", {alu_op, busy}, {2'b10, 1'b1});
      if (done) check("ph_done_not_busy", busy, 1'b0);
      if (alu_op == 2'b10) begin
        if (!prev_hi) begin
          exec_ctl = alu_ctl;
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected_wb: got a writeback, expected none at %0t", $time);
        end else begin
          rec = exp_q.pop_front();
          check("sb_exec_alu_ctl", exec_ctl, rec.ctl);
          check("sb_wb_alu_ctl_held", alu_ctl, rec.ctl);
          check("sb_reg_write", reg_write, rec.reg_write);
        end
      end
      prev_hi = (alu_op == 2'b10);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pcwrite"}, pc_write, 1'b0);
    check({tag, "_irwrite"}, ir_write, 1'b0);
    check({tag, "_regwrite"}, reg_write, 1'b0);
    check({tag, "_aluop"}, alu_op, 2'b00);
    check({tag, "_aluctl"}, alu_ctl, 4'hF);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_illegal"}, illegal, 1'b0);
    check({tag, "_count"}, count, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    start_1   = 1'b0;
    instr_1   = 32'hABCD_0020;
    fetch_idx = 0;
    load_main_prog(1'b0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_reset_values("rst");

    // Main program: ALU codes, cadence, DONE at cycle 25.
    fetch_idx = 0;
    load_main_prog(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check("run_fetch_cadence", pc_write, ((c - 1) % 4) == 0);
      check("run_done_low", done, 1'b0);
      if (c == 24) check("run_count_before_last", count, 5);
      tick();
    end
    check("run_done_high", done, 1'b1);
    check("run_count_final", count, 6);
    check("run_busy_low", busy, 1'b0);
    repeat (3) tick();
    check("run_done_held", {done, pc_write}, {1'b1, 1'b0});
    check("run_count_held", count, 6);
    check("run_sb_drained", exp_q.size(), 0);

    // RESET during EXECUTE of instruction 3.
    fetch_idx = 0;
    push_exp(4'd2, 1'b1);
    push_exp(4'd0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("rst_mid_in_execute", alu_op, 2'b10);
    check("rst_mid_count", count, 2);
    check("rst_mid_aluctl", alu_ctl, 4'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst_mid");
    for (int c = 0; c < 4; c++) begin
      check("rst_mid_quiet", {reg_write, pc_write, busy}, 3'b000);
      tick();
    end
    check("rst_mid_sb_drained", exp_q.size(), 0);

    // Unsupported funct 0x3F as instruction 2.
    fetch_idx = 0;
    prog = '{6'd32, 6'h3F, 6'd37, 6'd34, 6'd42, 6'd39};
`ifdef ILLEGAL_TRAP_EN
    push_exp(4'd2, 1'b1);
    push_exp(4'hF, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("trap_illegal", illegal, 1'b1);
    check("trap_count", count, 1);
    check("trap_idle_flags", {busy, done, pc_write}, 3'b000);
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("trap_start_ignored", {pc_write, busy}, 2'b00);
    end
    start = 1'b0;
    check("trap_illegal_sticky", illegal, 1'b1);
    check("trap_count_held", count, 1);
    check("trap_sb_drained", exp_q.size(), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("trap_rst");
`else
    for (int run = 0; run < 2; run++) begin
      push_exp(4'd2, 1'b1);
      push_exp(4'hF, 1'b0);
      push_exp(4'd1, 1'b1);
      push_exp(4'd6, 1'b1);
      push_exp(4'd7, 1'b1);
      push_exp(4'd12, 1'b1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (24) tick();
    check("nop_done", done, 1'b1);
    check("nop_count", count, 6);
    check("nop_illegal", illegal, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nop_restart_clears_illegal", illegal, 1'b0);
    check("nop_restart_clears_count", count, 0);
    check("nop_restart_fetch", pc_write, 1'b1);
    repeat (24) tick();
    check("nop_rerun_done", {done, illegal}, 2'b11);
    check("nop_rerun_count", count, 6);
    check("nop_sb_drained", exp_q.size(), 0);
`endif

    // START held high: no restart while busy, immediate restart from DONE.
    fetch_idx = 0;
    load_main_prog(1'b1);
    load_main_prog(1'b1);
    start = 1'b1;
    tick();
    check("hold_fetch", pc_write, 1'b1);
    repeat (23) tick();
    check("hold_no_restart_busy", busy, 1'b1);
    check("hold_count_mid", count, 5);
    tick();
    check("hold_done", done, 1'b1);
    check("hold_count_done", count, 6);
    tick();
    check("hold_restart_fetch", {pc_write, done}, 2'b10);
    check("hold_restart_count", count, 0);
    start = 1'b0;
    repeat (24) tick();
    check("hold_second_done", done, 1'b1);
    check("hold_second_count", count, 6);
    check("hold_sb_drained", exp_q.size(), 0);

    // MAX_INSTR = 1: one FETCH..WRITEBACK, DONE at cycle 5.
    start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("one_fetch", {pc_write_1, ir_write_1}, (c == 1) ? 2'b11 : 2'b00);
      check("one_regwrite", reg_write_1, c == 4);
      check("one_done_low", done_1, 1'b0);
      tick();
    end
    check("one_done", {done_1, busy_1, alu_op_1, illegal_1}, {1'b1, 1'b0, 2'b00, 1'b0});
    check("one_count", count_1, 1);
    check("one_aluctl", alu_ctl_1, 4'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_rtype_sequencer.md
# mips_rtype_sequencer

Multi-cycle control FSM for the R-type MIPS datapath (PC, PC adder, instruction memory/register, register file, ALU control, ALU). It sequences each instruction through fetch, decode, execute and write-back. During those phases it drives the PC, instruction-register and register-file write enables, and decodes the function field into the 4-bit ALU control code. It counts retired instructions, stops after a programmed count, and flags unsupported function codes.

## Interface
Parameters:
- MAX_INSTR, 6: instructions to retire before entering DONE; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the retired-instruction counter.

Ports:
- CLK, input, 1: clock; all state updates on posedge.
- RESET, input, 1: synchronous, active-high; sampled on posedge CLK.
- START, input, 1: level; sampled in IDLE and DONE only.
- INSTRUCTION, input, 32: current instruction-memory output. Only bits [5:0] (funct) are used.
- PCWrite, output, 1: PC load enable.
- IRWrite, output, 1: instruction-register load enable.
- RegWrite, output, 1: register-file write enable.
- ALUOp, output, 2: 2'b10 in EXECUTE/WRITEBACK, 2'b00 otherwise.
- ALUCtl, output, 4: registered ALU control code.
- BUSY, output, 1: high in FETCH/DECODE/EXECUTE/WRITEBACK.
- DONE, output, 1: high in DONE state.
- ILLEGAL, output, 1: sticky unsupported-funct flag.
- INSTR_COUNT, output, CNT_W: retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, DONE, HALT. State encoding is implementer's choice.
- IDLE:
  - START=1 goes to FETCH, with INSTR_COUNT cleared to 0 and ILLEGAL cleared.
  - Otherwise stay in IDLE.
- FETCH: PCWrite=1 and IRWrite=1 for exactly this cycle. Always goes to DECODE.
- DECODE: latch funct and map it to ALUCtl. Always goes to EXECUTE.
  - 32 (ADD) → 2
  - 34 (SUB) → 6
  - 36 (AND) → 0
  - 37 (OR) → 1
  - 39 (NOR) → 12
  - 42 (SLT) → 7
  - Any other funct → 15, and an internal illegal bit is set.
- EXECUTE: ALUCtl is held stable while the ALU settles. Always goes to WRITEBACK.
- WRITEBACK:
  - RegWrite=1 for this cycle only if the funct was legal.
  - INSTR_COUNT increments by 1 (wraps at 2^CNT_W; unreachable when MAX_INSTR is legal).
  - If the incremented count equals MAX_INSTR, go to DONE; otherwise go to FETCH.
  - Illegal-funct behaviour is governed by the Configuration section.
- DONE:
  - DONE=1; INSTR_COUNT is held.
  - START=1 behaves as in IDLE (clear the count, go to FETCH).
  - This block never resets the PC.
- HALT: entered only with the trap feature enabled.
  - ILLEGAL=1 and all enables are 0.
  - Exit only via RESET.
- START is ignored in FETCH, DECODE, EXECUTE, WRITEBACK and HALT.

## Timing
- Reset values: state=IDLE; PCWrite, IRWrite, RegWrite=0; ALUOp=0; ALUCtl=4'hF; BUSY, DONE, ILLEGAL=0; INSTR_COUNT=0.
- RESET has priority over every other input and applies in any state, including mid-instruction. If RESET is asserted during WRITEBACK, that cycle's increment does not occur.
- Enables (PCWrite, IRWrite, RegWrite) are decoded combinationally from the current state and are glitch-free relative to CLK.
- ALUCtl updates on the posedge that leaves DECODE. It is valid from EXECUTE entry until the next DECODE exit.
- Start latency: START sampled at edge N means FETCH is active in cycle N+1.
- Instruction cadence: 4 cycles per instruction, with FETCH pulses exactly 4 cycles apart.
- DONE timing: DONE rises in the cycle after the final WRITEBACK, i.e. 4×MAX_INSTR+1 cycles after the START sample.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An illegal funct sets ILLEGAL in WRITEBACK with RegWrite=0.
  - The count does not increment.
  - The next state is HALT.
- ILLEGAL_TRAP_EN undefined:
  - An illegal funct is a NOP: RegWrite=0 and the count increments.
  - ILLEGAL is set and sticky until START or RESET.
  - Sequencing continues normally; HALT is unreachable.

## Test plan
- Reset, then START=1 for 1 cycle with MAX_INSTR=6 and the funct sequence 32, 36, 37, 34, 42, 39 → ALUCtl in each EXECUTE is 2, 0, 1, 6, 7, 12; six RegWrite pulses; DONE=1 at cycle 25 after START; INSTR_COUNT=6.
- Cycle-level phase check → PCWrite and IRWrite high only in FETCH; RegWrite only in WRITEBACK; ALUOp=2'b10 exactly in EXECUTE/WRITEBACK; BUSY low in IDLE and DONE.
- RESET asserted during the EXECUTE of instruction 3 → next cycle in IDLE, all outputs at reset values, INSTR_COUNT=0, no RegWrite pulse.
- funct=0x3F as instruction 2:
  - With ILLEGAL_TRAP_EN → HALT, ILLEGAL=1, INSTR_COUNT=1, no further FETCH, START ignored.
  - Without ILLEGAL_TRAP_EN → no RegWrite for that instruction, ILLEGAL=1, run completes with INSTR_COUNT=6.
- START held high throughout the run → no restart while BUSY; in DONE it restarts immediately (count cleared, FETCH in the next cycle).
- MAX_INSTR=1 → a single FETCH..WRITEBACK sequence, DONE at cycle 5, INSTR_COUNT=1.
